// File: rtl/addsub_pkg.sv
// Shared defaults and ALU status-flag packing for the pipelined add/subtract unit.
package addsub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEGS  = 4;
    localparam int DEF_TAG_W = 5;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_W     = 3;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic cout, input logic ovf, input logic zero);
        logic [FLAG_W-1:0] f;
        f             = '0;
        f[FLAG_CARRY] = cout;
        f[FLAG_OVF]   = ovf;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry-chain segment: purely combinational SW-bit adder with carry in/out.
module addsub_seg #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: the carry chain is cut into SEGS registered segments,
// one segment resolved per stage, with a single global advance enable for flow control.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEGS  = DEF_SEGS,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SW = WIDTH / SEGS;

    if (WIDTH % SEGS != 0) begin : g_bad_segs
        $error("addsub_pipe: WIDTH must be a multiple of SEGS");
    end

    logic             adv;
    logic [SEGS-1:0]  vld_q, vld_d;
    logic [SEGS-1:0]  carry_q, carry_d;
    logic [WIDTH-1:0] sum_q [SEGS];
    logic [WIDTH-1:0] sum_d [SEGS];
    logic [WIDTH-1:0] a_q   [SEGS];
    logic [WIDTH-1:0] a_d   [SEGS];
    logic [WIDTH-1:0] b_q   [SEGS];
    logic [WIDTH-1:0] b_d   [SEGS];
    logic [TAG_W-1:0] tag_q [SEGS];
    logic [TAG_W-1:0] tag_d [SEGS];
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [SEGS-1:0]  src_vld, src_cin;
    logic [WIDTH-1:0] src_a   [SEGS];
    logic [WIDTH-1:0] src_b   [SEGS];
    logic [WIDTH-1:0] src_sum [SEGS];
    logic [TAG_W-1:0] src_tag [SEGS];
    logic [SW-1:0]    seg_s   [SEGS];
    logic             seg_c   [SEGS];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0 sees the input beat with B already inverted for subtract; later stages see their predecessor.
    always_comb begin
        src_vld[0] = in_valid;
        src_a[0]   = in_a;
        src_b[0]   = in_sub ? ~in_b : in_b;
        src_cin[0] = in_sub | in_cin;
        src_sum[0] = '0;
        src_tag[0] = in_tag;
        for (int k = 1; k < SEGS; k++) begin
            src_vld[k] = vld_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_cin[k] = carry_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_tag[k] = tag_q[k-1];
        end
    end

    for (genvar g = 0; g < SEGS; g++) begin : g_seg
        addsub_seg #(.SW(SW)) u_seg (
            .a    (src_a[g][g*SW +: SW]),
            .b    (src_b[g][g*SW +: SW]),
            .cin  (src_cin[g]),
            .s    (seg_s[g]),
            .cout (seg_c[g])
        );
    end

    always_comb begin
        vld_d   = vld_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < SEGS; k++) begin
            sum_d[k] = sum_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            tag_d[k] = tag_q[k];
        end
        if (adv) begin
            for (int k = 0; k < SEGS; k++) begin
                vld_d[k]               = src_vld[k];
                a_d[k]                 = src_a[k];
                b_d[k]                 = src_b[k];
                tag_d[k]               = src_tag[k];
                carry_d[k]             = seg_c[k];
                sum_d[k]               = src_sum[k];
                sum_d[k][k*SW +: SW]   = seg_s[k];
            end
            // Flags ride alongside the final sum so they add no latency.
            zero_d = (sum_d[SEGS-1] == '0);
            ovf_d  = (src_a[SEGS-1][WIDTH-1] == src_b[SEGS-1][WIDTH-1]) &&
                     (sum_d[SEGS-1][WIDTH-1] != src_a[SEGS-1][WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < SEGS; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < SEGS; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign out_valid = vld_q[SEGS-1];
    assign out_sum   = sum_q[SEGS-1];
    assign out_cout  = carry_q[SEGS-1];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_tag   = tag_q[SEGS-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: four instances (SEGS = 1, 2, 4, 8) fed the same beats, each scored
// against an arithmetic reference model.
module tb_addsub_pipe;

    localparam int W  = 32;
    localparam int TW = 5;
    localparam int ND = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic          zero;
        logic [TW-1:0] tag;
    } beat_t;

    function automatic int segs_of(input int i);
        return 1 << i;
    endfunction

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sub = 1'b0;
    logic          in_cin = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          all_ready;
    logic          dut_valid;

    logic          d_in_ready  [ND];
    logic          d_out_valid [ND];
    logic          d_cout      [ND];
    logic          d_ovf       [ND];
    logic          d_zero      [ND];
    logic [W-1:0]  d_sum       [ND];
    logic [TW-1:0] d_tag       [ND];

    int    checks = 0;
    int    failures = 0;
    beat_t beats[$];
    int    rd [ND];

    always #5 clk = ~clk;

    // A beat is offered only when every instance can take it, so all four see identical accepts.
    assign all_ready = d_in_ready[0] & d_in_ready[1] & d_in_ready[2] & d_in_ready[3];
    assign dut_valid = in_valid && all_ready;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        addsub_pipe #(.WIDTH(W), .SEGS(segs_of(g)), .TAG_W(TW)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (dut_valid),
            .in_ready  (d_in_ready[g]),
            .in_a      (in_a),
            .in_b      (in_b),
            .in_sub    (in_sub),
            .in_cin    (in_cin),
            .in_tag    (in_tag),
            .out_valid (d_out_valid[g]),
            .out_ready (out_ready),
            .out_sum   (d_sum[g]),
            .out_cout  (d_cout[g]),
            .out_ovf   (d_ovf[g]),
            .out_zero  (d_zero[g]),
            .out_tag   (d_tag[g])
        );
    end

    function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, input logic cin, input logic [TW-1:0] tag);
        beat_t       m;
        longint      sa, sb, sr;
        logic [W:0]  u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            u      = {1'b0, a} - {1'b0, b};
            m.cout = (a >= b);
            sr     = sa - sb;
        end else begin
            u      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            m.cout = u[W];
            sr     = sa + sb + longint'(cin);
        end
        m.sum  = u[W-1:0];
        m.ovf  = (sr > SMAX) || (sr < SMIN);
        m.zero = (m.sum == '0);
        m.tag  = tag;
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic resync();
        for (int d = 0; d < ND; d++) rd[d] = beats.size();
    endtask

    // One clock cycle: drive inputs after the falling edge, score outputs, then cross the rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin, input logic [TW-1:0] tag,
                                 input logic rdy, output logic acc);
        logic retire [ND];
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_cin    = cin;
        in_tag    = tag;
        out_ready = rdy;
        #1;
        acc = v && all_ready;
        for (int d = 0; d < ND; d++) begin
            checkOutput($sformatf("in_ready[%0d]", d), 64'(d_in_ready[d]), 64'(!d_out_valid[d] || rdy));
            retire[d] = d_out_valid[d] && rdy;
            if (d_out_valid[d]) begin
                if (rd[d] < beats.size()) begin
                    checkOutput($sformatf("sum[%0d]", d),  64'(d_sum[d]),  64'(beats[rd[d]].sum));
                    checkOutput($sformatf("cout[%0d]", d), 64'(d_cout[d]), 64'(beats[rd[d]].cout));
                    checkOutput($sformatf("ovf[%0d]", d),  64'(d_ovf[d]),  64'(beats[rd[d]].ovf));
                    checkOutput($sformatf("zero[%0d]", d), 64'(d_zero[d]), 64'(beats[rd[d]].zero));
                    checkOutput($sformatf("tag[%0d]", d),  64'(d_tag[d]),  64'(beats[rd[d]].tag));
                end else begin
                    checkOutput($sformatf("spurious_valid[%0d]", d), 64'(d_out_valid[d]), 64'd0);
                end
            end
        end
        if (acc) beats.push_back(model(a, b, sub, cin, tag));
        @(posedge clk);
        for (int d = 0; d < ND; d++) if (retire[d]) rd[d]++;
        @(negedge clk);
    endtask

    task automatic sendBeat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin, input logic [TW-1:0] tag);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            applyStimulus(1'b1, a, b, sub, cin, tag, 1'b1, acc);
            n++;
        end
        checkOutput("accept_timeout", 64'(acc), 64'd1);
    endtask

    // Drain outstanding results; pattern!=0 replays the 1-0-0-1 ready pattern.
    task automatic drain(input bit pattern);
        logic acc;
        int   n;
        bit   busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < 300) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, pattern ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1, acc);
            n++;
            busy = 1'b0;
            for (int d = 0; d < ND; d++) if (rd[d] < beats.size()) busy = 1'b1;
        end
        for (int d = 0; d < ND; d++)
            checkOutput($sformatf("drained[%0d]", d), 64'(rd[d]), 64'(beats.size()));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic acc;
        int   tag_n, guard, sent;

        // Reset held with a beat offered: nothing may enter or appear.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h1234_5678;
        in_b      = 32'h0000_0001;
        in_tag    = 5'd7;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            checkOutput($sformatf("reset_valid[%0d]", d), 64'(d_out_valid[d]), 64'd0);
            checkOutput($sformatf("reset_sum[%0d]", d),   64'(d_sum[d]),       64'd0);
            checkOutput($sformatf("reset_cout[%0d]", d),  64'(d_cout[d]),      64'd0);
            checkOutput($sformatf("reset_ovf[%0d]", d),   64'(d_ovf[d]),       64'd0);
            checkOutput($sformatf("reset_zero[%0d]", d),  64'(d_zero[d]),      64'd0);
            checkOutput($sformatf("reset_tag[%0d]", d),   64'(d_tag[d]),       64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resync();

        // Latency: a lone beat must surface exactly SEGS edges after acceptance.
        sendBeat(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 5'd3);
        for (int n = 1; n <= 10; n++) begin
            for (int d = 0; d < ND; d++)
                checkOutput($sformatf("latency_n%0d[%0d]", n, d), 64'(d_out_valid[d]), 64'(n == segs_of(d)));
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, acc);
        end
        drain(1'b0);

        // Carry ripple, subtract and overflow corners.
        sendBeat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5'd1);
        sendBeat(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5'd2);
        sendBeat(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 5'd3);
        sendBeat(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5'd4);
        sendBeat(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 5'd5);
        sendBeat(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 5'd6);
        sendBeat(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 5'd7);
        sendBeat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5'd8);
        sendBeat(32'h0000_0009, 32'h0000_0009, 1'b1, 1'b1, 5'd9);
        drain(1'b0);

        // Backpressure: tags 0..9 with out_ready cycling 1-0-0-1.
        tag_n = 0;
        guard = 0;
        while (tag_n < 10 && guard < 200) begin
            applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          TW'(tag_n), ((guard % 4) == 0 || (guard % 4) == 3), acc);
            if (acc) tag_n++;
            guard++;
        end
        checkOutput("bp_sent", 64'(tag_n), 64'd10);
        drain(1'b1);

        // Reset with three beats in flight: they must vanish.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b0, TW'(20 + i), 1'b1, acc);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++)
            checkOutput($sformatf("midrst_valid[%0d]", d), 64'(d_out_valid[d]), 64'd0);
        in_valid = 1'b0;
        resync();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, acc);
        drain(1'b0);

        // Random traffic with random backpressure.
        sent  = 0;
        guard = 0;
        while (sent < 10000 && guard < 80000) begin
            applyStimulus($urandom_range(0, 4) != 0, pick_operand(), pick_operand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom),
                          $urandom_range(0, 3) != 0, acc);
            if (acc) sent++;
            guard++;
        end
        checkOutput("random_sent", 64'(sent), 64'd10000);
        drain(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
